// File: rtl/cpu_run_ctrl.sv
// Board run controller: button debounce, stretched core reset, run/step/halt
// clock-enable sequencing, exit/success latching and executed-cycle counter.
`timescale 1ns/1ps

module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 button_reset_n,
    input  logic                 button_step_n,
    input  logic                 step_mode,
    input  logic                 core_exit,
    input  logic                 core_success,
    output logic                 core_reset,
    output logic                 core_clock_en,
    output logic                 halted,
    output logic                 success,
    output logic                 exit,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RST_W-1:0]     RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam int unsigned BTN_RESET = 0;
    localparam int unsigned BTN_STEP  = 1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_WAIT_STEP,
        ST_STEP,
        ST_HALT
    } state_t;

    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state;
    state_t          state_nxt_c;
    logic [RST_W-1:0] rst_cnt;
    logic            rst_done_c;
    logic            active_c;

    assign btn_raw = {button_step_n, button_reset_n};

    // Two-flop synchroniser plus stability counter; press pulses on a debounced fall.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1     <= '1;
            sync2     <= '1;
            deb       <= '1;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                        press[i]  <= ~sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    function automatic state_t next_state(input state_t s, input logic done,
                                          input logic step_press, input logic mode,
                                          input logic cexit);
        next_state = ST_RESET;
        case (s)
            ST_RESET:     next_state = done ? (mode ? ST_WAIT_STEP : ST_RUN) : ST_RESET;
            ST_RUN:       next_state = cexit ? ST_HALT : (mode ? ST_WAIT_STEP : ST_RUN);
            ST_WAIT_STEP: next_state = step_press ? ST_STEP : (mode ? ST_WAIT_STEP : ST_RUN);
            ST_STEP:      next_state = cexit ? ST_HALT : (mode ? ST_WAIT_STEP : ST_RUN);
            ST_HALT:      next_state = ST_HALT;
            default:      next_state = ST_RESET;
        endcase
    endfunction

    assign rst_done_c  = (rst_cnt == RST_LAST);
    assign active_c    = (state == ST_RUN) || (state == ST_STEP);
    assign state_nxt_c = next_state(state, rst_done_c, press[BTN_STEP], step_mode, core_exit);

    // A reset press outranks every other event, including core_exit in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n || press[BTN_RESET]) begin
            state         <= ST_RESET;
            rst_cnt       <= '0;
            core_reset    <= 1'b1;
            core_clock_en <= 1'b1;
            halted        <= 1'b0;
            success       <= 1'b0;
            exit          <= 1'b0;
            cycle_count   <= '0;
        end else begin
            state         <= state_nxt_c;
            rst_cnt       <= (state == ST_RESET && !rst_done_c) ? rst_cnt + RST_W'(1) : '0;
            core_reset    <= (state_nxt_c == ST_RESET);
            core_clock_en <= (state_nxt_c inside {ST_RESET, ST_RUN, ST_STEP});
            halted        <= (state_nxt_c == ST_HALT);
            if (active_c) begin
                success <= core_success;
                exit    <= core_exit;
                if (cycle_count != CNT_MAX) begin
                    cycle_count <= cycle_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: reset stretch, exit latch, debounce, stepping, saturation.
`timescale 1ns/1ps

module tb_cpu_run_ctrl;

    localparam int unsigned RST_CYC = 16;
    localparam int unsigned DB_CYC  = 4;
    localparam int unsigned CW      = 4;
    localparam int          CNT_SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          button_reset_n;
    logic          button_step_n;
    logic          step_mode;
    logic          core_exit;
    logic          core_success;
    logic          core_reset;
    logic          core_clock_en;
    logic          halted;
    logic          success;
    logic          exit;
    logic [CW-1:0] cycle_count;

    always #5 clock = ~clock;

    cpu_run_ctrl #(
        .RESET_CYCLES    (RST_CYC),
        .DEBOUNCE_CYCLES (DB_CYC),
        .CNT_WIDTH       (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .button_reset_n (button_reset_n),
        .button_step_n  (button_step_n),
        .step_mode      (step_mode),
        .core_exit      (core_exit),
        .core_success   (core_success),
        .core_reset     (core_reset),
        .core_clock_en  (core_clock_en),
        .halted         (halted),
        .success        (success),
        .exit           (exit),
        .cycle_count    (cycle_count)
    );

    typedef struct {
        string tag;
        int    cr;
        int    en;
        int    h;
        int    s;
        int    x;
        int    cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_SAT) ? CNT_SAT : v;
    endfunction

    task automatic push_exp(input string tag, input int cr, input int en, input int h,
                            input int s, input int x, input int cnt);
        exp_t e;
        e.tag = tag; e.cr = cr; e.en = en; e.h = h; e.s = s; e.x = x; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        int   depth;
        depth = sb_q.size();
        if (depth == 0) begin
            check_eq("sb_underflow", depth, 1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({e.tag, ".core_reset"},    int'(core_reset),    e.cr);
        check_eq({e.tag, ".core_clock_en"}, int'(core_clock_en), e.en);
        check_eq({e.tag, ".halted"},        int'(halted),        e.h);
        check_eq({e.tag, ".success"},       int'(success),       e.s);
        check_eq({e.tag, ".exit"},          int'(exit),          e.x);
        check_eq({e.tag, ".cycle_count"},   int'(cycle_count),   e.cnt);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Expected outputs are queued with the stimulus and retired after the clock edge.
    task automatic cyc(input string tag, input int cr, input int en, input int h,
                       input int s, input int x, input int cnt);
        push_exp(tag, cr, en, h, s, x, cnt);
        tick();
        pop_check();
    endtask

    task automatic step_press(input int hold, input int exp_count);
        int seen;
        seen = 0;
        button_step_n = 1'b0;
        repeat (hold) begin
            tick();
            if (core_clock_en) seen++;
        end
        button_step_n = 1'b1;
        repeat (10) begin
            tick();
            if (core_clock_en) seen++;
        end
        check_eq($sformatf("step_pulses_hold%0d", hold), seen, 1);
        check_eq($sformatf("step_count_hold%0d", hold), int'(cycle_count), exp_count);
    endtask

    initial begin
        reset_n        = 1'b0;
        button_reset_n = 1'b1;
        button_step_n  = 1'b1;
        step_mode      = 1'b0;
        core_exit      = 1'b0;
        core_success   = 1'b0;
        repeat (3) tick();
        push_exp("reset", 1, 1, 0, 0, 0, 0);
        pop_check();

        // Power-up: core_reset high for RST_CYC cycles, then free-run counting.
        reset_n = 1'b1;
        for (int i = 0; i < int'(RST_CYC); i++) begin
            push_exp($sformatf("pwr_rst%0d", i), 1, 1, 0, 0, 0, 0);
            pop_check();
            tick();
        end
        push_exp("run0", 0, 1, 0, 0, 0, 0);
        pop_check();
        for (int k = 1; k <= 5; k++) cyc($sformatf("run%0d", k), 0, 1, 0, 0, 0, k);

        // Exit latches status and freezes everything.
        core_exit    = 1'b1;
        core_success = 1'b1;
        cyc("exit", 0, 0, 1, 1, 1, 6);
        for (int i = 0; i < 6; i++) begin
            core_exit    = 1'(i % 2);
            core_success = 1'((i + 1) % 2);
            cyc("halt_hold", 0, 0, 1, 1, 1, 6);
        end
        core_exit    = 1'b0;
        core_success = 1'b0;

        // Short reset-button glitch is rejected.
        button_reset_n = 1'b0;
        repeat (2) cyc("glitch_low", 0, 0, 1, 1, 1, 6);
        button_reset_n = 1'b1;
        repeat (8) cyc("glitch_after", 0, 0, 1, 1, 1, 6);

        // Held press leaves HALT after 2 sync + DB_CYC stable + 1 state cycles.
        button_reset_n = 1'b0;
        repeat (6) cyc("rst_btn_wait", 0, 0, 1, 1, 1, 6);
        cyc("rst_btn_hit", 1, 1, 0, 0, 0, 0);

        // Second press mid-countdown restarts it: core_reset spans 15 + 16 cycles.
        button_reset_n = 1'b1;
        step_mode      = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 9)  button_reset_n = 1'b0;
            if (i == 20) button_reset_n = 1'b1;
            cyc($sformatf("rst_count%0d", i), 1, 1, 0, 0, 0, 0);
        end
        cyc("wait_step", 0, 0, 0, 0, 0, 0);

        // Single-stepping: one enabled cycle per press, long holds included.
        step_press(8, 1);
        step_press(8, 2);
        step_press(100, 3);

        // Back to free-run; step presses in RUN are ignored; counter saturates.
        step_mode = 1'b0;
        cyc("mode_run", 0, 1, 0, 0, 0, 3);
        for (int i = 1; i <= 20; i++) begin
            if (i == 1)  button_step_n = 1'b0;
            if (i == 10) button_step_n = 1'b1;
            cyc($sformatf("run_sat%0d", i), 0, 1, 0, 0, 0, sat(3 + i));
        end

        // Reset press and core_exit together: reset wins.
        button_reset_n = 1'b0;
        repeat (6) cyc("pre_rst", 0, 1, 0, 0, 0, CNT_SAT);
        core_exit    = 1'b1;
        core_success = 1'b1;
        cyc("rst_vs_exit", 1, 1, 0, 0, 0, 0);
        core_exit      = 1'b0;
        core_success   = 1'b0;
        button_reset_n = 1'b1;
        repeat (3) cyc("rst_after", 1, 1, 0, 0, 0, 0);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
